mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//   Parametrised, multi-cycle MEM pipeline stage between EX/MEM and MEM/WB.
//   Decodes load/store ALU ops, drives a req/ack data bus and realigns
//   big-endian byte lanes: LB/LBU/LH/LHU/LW/SB/SH/SW.
//   Stalls the pipeline while a bus transfer is pending. Registers the
//   writeback result. Raises a bus exception on error or timeout.
// PARAMETERS
//   DATA_W   32  data bus width, 32 or 64; SEL_W = DATA_W/8 byte enables
//   ADDR_W   32  address width
//   TMO_CYC  16  BUS-state cycles without ack before abort (>=2)
// PORTS
//   clk            in   1        clock, rising edge
//   rst            in   1        asynchronous reset, active low
//   valid_i        in   1        EX/MEM slot holds an instruction
//   aluop_i        in   8        AluOpBus op code
//   mem_addr_i     in   ADDR_W   effective address
//   reg2_i         in   DATA_W   store data
//   wd_i/wreg_i    in   5/1      destination register / write enable
//   wdata_i        in   DATA_W   ALU result, passed through for non-memory ops
//   stall_req_o    out  1        hold EX and earlier stages
//   valid_o        out  1        MEM/WB slot valid
//   wd_o/wreg_o    out  5/1      registered destination / write enable
//   wdata_o        out  DATA_W   registered writeback data
//   exc_o          out  1        one-cycle pulse: bus error or timeout
//   bus_req_o      out  1        transfer request, held until ack/err/timeout
//   bus_we_o       out  1        1 = write
//   bus_addr_o     out  ADDR_W   bus address, low lane bits forced to 0
//   bus_sel_o      out  SEL_W    byte enables; bit SEL_W-1 = lane 0 (MSB byte)
//   bus_wdata_o    out  DATA_W   replicated store data
//   bus_rdata_i    in   DATA_W   read data, valid with ack
//   bus_ack_i      in   1        transfer complete
//   bus_err_i      in   1        transfer failed
// BEHAVIOUR
//   - Reset (rst=0, async): every output 0; state IDLE; timeout counter 0.
//     Reset during BUS drops bus_req_o immediately; no retry after release.
//   - States: IDLE, BUS.
//   - IDLE, valid_i, non-memory op: next edge valid_o=1,
//     {wd,wreg,wdata}_o = inputs. Latency 1. No stall.
//   - IDLE, valid_i, memory op: stall_req_o=1 combinationally. Next edge:
//     bus_* registered, bus_req_o=1, enter BUS, counter cleared.
//     During that cycle valid_o=0.
//   - BUS: bus_* held stable. stall_req_o=1 except in the terminating cycle
//     (ack, err or counter==TMO_CYC-1), where it is 0. On the next edge:
//     return to IDLE, bus_req_o=0, valid_o=1.
//   - Load result: lane = addr[log2(SEL_W)-1:0]; lane 0 is the MSB byte.
//     LB/LH sign-extend to DATA_W; LBU/LHU zero-extend.
//     LW on DATA_W=64 selects the 32-bit half addressed by addr[2] and
//     sign-extends it.
//   - Store data: SB replicates the byte across all lanes; SH the halfword;
//     SW the word. bus_sel_o marks the addressed lanes only.
//     Store: wreg_o=0.
//   - err, or ack and err together: err wins. Same for timeout:
//     exc_o=1 for one cycle, wreg_o=0, valid_o=1; no register write.
//   - ack arriving while bus_req_o=0 is ignored.
//   - Unknown aluop_i: treated as non-memory.
// CONFIGURATION
//   MEM_ALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]!=0, or LW/SW with
//     addr[1:0]!=0, start no bus transfer. Next edge: exc_o=1, valid_o=1,
//     wreg_o=0, no stall.
//   Not defined: low bits beyond the access size are ignored
//     (LH at addr 0x3 acts as LH at addr 0x2). exc_o only from bus err/timeout.
// STRUCTURE
//   defines.v: EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP codes, state encodings,
//     RstEnable=1'b0 for this block.
//   Sub-module mem_lane_align (combinational): lane select, sign/zero
//     extension, store replication and byte-enable generation.
//     Parametrised by DATA_W.
// TESTING
//   1 DATA_W=32, LB at addr 0x1, rdata 0x12F45678, ack after 3 BUS cycles
//     -> wdata_o=0xFFFFFFF4, bus_sel_o=4'b0100, stall_req_o high for 3 cycles.
//   2 LBU at same address and data -> wdata_o=0x000000F4.
//     LHU at addr 0x2 -> wdata_o=0x00005678.
//   3 SH at addr 0x2, reg2_i=0xAAAABEEF -> bus_wdata_o=0xBEEFBEEF,
//     bus_sel_o=4'b0011, bus_we_o=1, wreg_o=0.
//   4 LW with no ack -> after TMO_CYC=16 BUS cycles: exc_o pulse,
//     bus_req_o=0, wreg_o=0. Repeat with ack and err in the same cycle
//     -> exc_o pulse.
//   5 rst low mid-BUS -> all outputs 0 asynchronously. After release,
//     IDLE accepts an ADD: valid_o=1 after 1 cycle.
//   6 MEM_ALIGN_CHECK_EN, SW at addr 0x1 -> no bus_req_o, exc_o=1 next
//     cycle. Without the macro: write to 0x0, bus_sel_o=4'b1111.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared definitions for the MEM pipeline stage: load/store ALU op codes,
//   FSM state encodings, the reset-active level and small op-decode helpers.
//   No ports (package).
package mem_access_unit_pkg;

  // Load/store op codes on the AluOpBus
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  // FSM state encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUS  = 1'b1;

  // Level of rst that holds the block in reset
  localparam logic RstEnable = 1'b0;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  function automatic logic is_mem_op(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_mem_op = 1'b1;
      default:                         is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_store_op = 1'b1;
      default:                         is_store_op = 1'b0;
    endcase
  endfunction

  function automatic acc_size_e op_size(input logic [7:0] op);
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: op_size = SZ_HALF;
      EXE_LW_OP, EXE_SW_OP:             op_size = SZ_WORD;
      default:                          op_size = SZ_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
//   Combinational big-endian lane logic: byte-enable generation, store data
//   replication and load data selection with sign/zero extension.
//   Lane 0 is the most significant byte of the bus.
// Ports
//   aluop      in   8        load/store op code
//   lane       in   LANE_W   byte lane of the access (low address bits)
//   store_data in   DATA_W   register value to be stored
//   rdata      in   DATA_W   bus read data
//   sel        out  SEL_W    byte enables, bit SEL_W-1 = lane 0
//   wdata_rep  out  DATA_W   store data replicated across the bus
//   load_data  out  DATA_W   extended load result
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int SEL_W = DATA_W / 8,
  localparam int LANE_W = $clog2(SEL_W)
) (
  input  logic [7:0]        aluop,
  input  logic [LANE_W-1:0] lane,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] load_data
);

  acc_size_e         size_s;
  int                lane_int_s;
  int                base_s;
  int                nbytes_s;
  int                shift_s;
  logic [SEL_W-1:0]  mask_s;
  logic [DATA_W-1:0] rd_shift_s;

  // Access geometry: first lane of the naturally aligned field and its width
  always_comb begin
    size_s     = op_size(aluop);
    lane_int_s = int'(lane);
    case (size_s)
      SZ_HALF: begin
        nbytes_s = 2;
        mask_s   = SEL_W'(2'b11);
      end
      SZ_WORD: begin
        nbytes_s = 4;
        mask_s   = SEL_W'(4'b1111);
      end
      default: begin
        nbytes_s = 1;
        mask_s   = SEL_W'(1'b1);
      end
    endcase
    // low address bits below the access size are dropped
    base_s = lane_int_s - (lane_int_s % nbytes_s);
    // lanes after the field sit below it in big-endian order
    shift_s = SEL_W - base_s - nbytes_s;
  end

  // Byte enables and right-justified read data
  always_comb begin
    sel        = mask_s << shift_s;
    rd_shift_s = rdata >> (shift_s * 8);
  end

  // Store replication and load extension
  always_comb begin
    case (size_s)
      SZ_HALF: wdata_rep = {(SEL_W / 2){store_data[15:0]}};
      SZ_WORD: wdata_rep = {(SEL_W / 4){store_data[31:0]}};
      default: wdata_rep = {SEL_W{store_data[7:0]}};
    endcase
    case (aluop)
      EXE_LB_OP:  load_data = DATA_W'($signed(rd_shift_s[7:0]));
      EXE_LBU_OP: load_data = DATA_W'(rd_shift_s[7:0]);
      EXE_LH_OP:  load_data = DATA_W'($signed(rd_shift_s[15:0]));
      EXE_LHU_OP: load_data = DATA_W'(rd_shift_s[15:0]);
      EXE_LW_OP:  load_data = DATA_W'($signed(rd_shift_s[31:0]));
      default:    load_data = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Multi-cycle MEM pipeline stage. Non-memory ops pass through with one
//   cycle of latency; loads/stores run a req/ack bus transfer while the
//   pipeline is stalled, then register the realigned writeback result.
//   Bus error or timeout (TMO_CYC BUS cycles) raises a one-cycle exc_o.
//   Optional feature macro: MEM_ALIGN_CHECK_EN -- misaligned LH/LHU/SH/LW/SW
//   raise exc_o without a bus transfer; when undefined the low address bits
//   below the access size are ignored.
// Ports
//   clk, rst (async, active low)
//   valid_i, aluop_i, mem_addr_i, reg2_i, wd_i, wreg_i, wdata_i : EX/MEM slot
//   stall_req_o                                                 : stall EX
//   valid_o, wd_o, wreg_o, wdata_o, exc_o                       : MEM/WB slot
//   bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o     : bus request
//   bus_rdata_i, bus_ack_i, bus_err_i                           : bus response
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TMO_CYC = 16,
  localparam int SEL_W  = DATA_W / 8,
  localparam int LANE_W = $clog2(SEL_W),
  localparam int CNT_W  = $clog2(TMO_CYC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_req_o,
  output logic              valid_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              exc_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  input  logic              bus_err_i
);

  logic [0:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [7:0]        op_r;
  logic [LANE_W-1:0] lane_r;
  logic [4:0]        wd_r;
  logic              wreg_r;

  logic [7:0]        al_op_s;
  logic [LANE_W-1:0] al_lane_s;
  logic [SEL_W-1:0]  sel_s;
  logic [DATA_W-1:0] rep_s;
  logic [DATA_W-1:0] load_s;
  logic              misalign_s;
  logic              term_s;
  logic              fail_s;

  // Lane logic sees the incoming op while idle, the captured op during BUS
  always_comb begin
    if (state_r == ST_BUS) begin
      al_op_s   = op_r;
      al_lane_s = lane_r;
    end else begin
      al_op_s   = aluop_i;
      al_lane_s = mem_addr_i[LANE_W-1:0];
    end
  end

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .aluop      (al_op_s),
    .lane       (al_lane_s),
    .store_data (reg2_i),
    .rdata      (bus_rdata_i),
    .sel        (sel_s),
    .wdata_rep  (rep_s),
    .load_data  (load_s)
  );

  // Misaligned-access detection for the incoming op
  always_comb begin
    misalign_s = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    case (aluop_i)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misalign_s = mem_addr_i[0];
      EXE_LW_OP, EXE_SW_OP:             misalign_s = (mem_addr_i[1:0] != 2'b00);
      default:                          misalign_s = 1'b0;
    endcase
`else
    misalign_s = 1'b0;
`endif
  end

  // Transfer termination; error and timeout take priority over ack
  always_comb begin
    if (state_r == ST_BUS) begin
      fail_s = bus_err_i | (cnt_r == CNT_W'(TMO_CYC - 1));
      term_s = fail_s | bus_ack_i;
    end else begin
      fail_s = 1'b0;
      term_s = 1'b0;
    end
  end

  // Stall request, forced low while reset is held
  always_comb begin
    stall_req_o = 1'b0;
    if (rst == RstEnable) begin
      stall_req_o = 1'b0;
    end else if (state_r == ST_IDLE) begin
      stall_req_o = valid_i & is_mem_op(aluop_i) & ~misalign_s;
    end else begin
      stall_req_o = ~term_s;
    end
  end

  // FSM, bus request registers and MEM/WB output registers
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      op_r        <= 8'h00;
      lane_r      <= {LANE_W{1'b0}};
      wd_r        <= 5'd0;
      wreg_r      <= 1'b0;
      valid_o     <= 1'b0;
      wd_o        <= 5'd0;
      wreg_o      <= 1'b0;
      wdata_o     <= {DATA_W{1'b0}};
      exc_o       <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= {ADDR_W{1'b0}};
      bus_sel_o   <= {SEL_W{1'b0}};
      bus_wdata_o <= {DATA_W{1'b0}};
    end else begin
      // writeback slot is empty unless a branch below fills it
      valid_o <= 1'b0;
      wreg_o  <= 1'b0;
      exc_o   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (valid_i) begin
            if (!is_mem_op(aluop_i)) begin
              valid_o <= 1'b1;
              wd_o    <= wd_i;
              wreg_o  <= wreg_i;
              wdata_o <= wdata_i;
            end else if (misalign_s) begin
              valid_o <= 1'b1;
              wd_o    <= wd_i;
              exc_o   <= 1'b1;
              wdata_o <= {DATA_W{1'b0}};
            end else begin
              state_r     <= ST_BUS;
              cnt_r       <= {CNT_W{1'b0}};
              op_r        <= aluop_i;
              lane_r      <= mem_addr_i[LANE_W-1:0];
              wd_r        <= wd_i;
              wreg_r      <= wreg_i;
              bus_req_o   <= 1'b1;
              bus_we_o    <= is_store_op(aluop_i);
              bus_addr_o  <= {mem_addr_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
              bus_sel_o   <= sel_s;
              bus_wdata_o <= is_store_op(aluop_i) ? rep_s : {DATA_W{1'b0}};
            end
          end
        end
        ST_BUS: begin
          if (term_s) begin
            state_r   <= ST_IDLE;
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
            valid_o   <= 1'b1;
            wd_o      <= wd_r;
            if (fail_s) begin
              exc_o   <= 1'b1;
              wdata_o <= {DATA_W{1'b0}};
            end else if (is_store_op(op_r)) begin
              wdata_o <= {DATA_W{1'b0}};
            end else begin
              wreg_o  <= wreg_r;
              wdata_o <= load_s;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          bus_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
